fracclk_gen: RTL
================

Name: fracclk_gen

Overview:
- Multi-channel fractional clock-enable generator. Derives per-channel tick strobes (UART 16x baud, sample clocks, timers) from one PLL output clock using phase accumulators, so non-integer rates need no dedicated PLL output.
- Qualifies the PLL locked signal through a synchroniser and a settle filter. Produces a clean ready flag and a downstream active-low reset.
- Sits directly after the PLL wrapper in each board top level.

Parameters:
CHANNELS, 2, number of independent tick channels (1..8)
ACC_W, 32, phase accumulator / increment width (8..32)
LOCK_FILTER, 1024, cycles lock must stay continuously high before RUN (>=2)

Ports:
clk  in  1  PLL output clock; the only clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  raw PLL lock, asynchronous to clk
cfg_we  in  1  config write strobe, single cycle
cfg_ch  in  max(1,$clog2(CHANNELS))  channel select for the write
cfg_inc  in  ACC_W  phase increment for the selected channel
cfg_en  in  1  enable for the selected channel
tick  out  CHANNELS  per-channel one-cycle enable strobes
ready  out  1  high while in RUN
rst_out_n  out  1  downstream reset, low unless in RUN

Behaviour:
- Reset (rst_n=0, async):
  - tick=0, ready=0, rst_out_n=0.
  - Synchroniser flops=0, state=WAIT_LOCK, filter count=0.
  - All inc=0, en=0, acc=0.
- Lock synchroniser: 2 flops; lock_s is pll_locked delayed 2 edges.
- FSM states WAIT_LOCK, SETTLE, RUN; state register is registered.
  - WAIT_LOCK: cnt=0; lock_s=1 -> SETTLE.
  - SETTLE: lock_s=0 -> WAIT_LOCK, cnt=0. Otherwise cnt++. At cnt==LOCK_FILTER-1 -> RUN.
  - RUN: lock_s=0 -> WAIT_LOCK.
- ready = (state==RUN); rst_out_n = (state==RUN). Both are decoded from the state register, so they are glitch-free.
- Latency: pll_locked rises before edge 1 and stays high -> ready=1 after edge 3+LOCK_FILTER.
- Accumulators:
  - Per channel: {carry, acc_next} = acc + inc, computed at ACC_W+1 bits.
  - Update each cycle when state==RUN and en=1; tick[i] <= carry, registered.
  - Tick rate = f_clk * inc / 2^ACC_W.
  - Outside RUN, or en=0: acc <= 0, tick[i] <= 0.
- Config write (cfg_we=1):
  - inc[cfg_ch] <= cfg_inc and en[cfg_ch] <= cfg_en on that edge.
  - acc[cfg_ch] <= 0 and tick[cfg_ch] <= 0 on the same edge (phase realign). The new increment is first applied on the next edge.
  - cfg_ch >= CHANNELS: write ignored, no state changes.
  - Writes are accepted in every FSM state. Config registers survive lock loss; only rst_n clears them.
- Boundaries:
  - inc=0: never ticks.
  - inc=2^ACC_W-1: ticks every cycle except once per 2^ACC_W cycles.
  - Accumulator wraps modulo 2^ACC_W with no saturation.
  - Lock drop in RUN: ready and rst_out_n fall after 2 sync edges + 1 edge. The next edge also clears acc and tick.
  - Lock glitch in SETTLE restarts the filter from 0.
  - rst_n asserted mid-operation: all outputs go to reset values immediately (async). Release is clean because all state returns to defaults.

Decomposition:
- Package fracclk_pkg holds:
  - state enum (WAIT_LOCK=0, SETTLE=1, RUN=2);
  - function for the cfg_ch width;
  - localparam helper computing inc = round(f_out*2^ACC_W/f_clk), for benches and board tops.
- Sub-module fracclk_acc: one channel's accumulator, inc/en registers and tick flop, instantiated CHANNELS times via generate.

Test Plan:
- Reset: rst_n=0 with pll_locked=1 -> tick=0, ready=0, rst_out_n=0. Release with LOCK_FILTER=8 -> ready=1 and rst_out_n=1 exactly after edge 11.
- Lock glitch: LOCK_FILTER=8; pll_locked low for 1 cycle during SETTLE after 5 counts -> filter restarts. ready rises 8+ cycles after lock_s returns, never earlier.
- Rate: ACC_W=8; ch0 inc=64,en=1; ch1 inc=3,en=1; in RUN -> tick[0] every 4th cycle, tick[1] 3 ticks per 256 cycles. ACC_W=32 @50 MHz, inc=158329674 -> 1843200 +/-1 ticks per 50e6 cycles.
- Reconfig: mid-run, write ch0 inc=128 -> acc0 cleared on the write edge; ticks every 2nd cycle starting 2 cycles after the write. ch1 is unaffected.
- Lock loss in RUN: drop pll_locked -> ready and rst_out_n low 3 edges later, ticks stop. Re-lock -> config retained, same tick pattern resumes after the filter.
- Edge writes: cfg_ch=CHANNELS (CHANNELS=2, ch width 1 so use CHANNELS=3, cfg_ch=3) -> no register changes. inc=0,en=1 -> no ticks over 1000 cycles. rst_n pulse mid-run -> immediate zero outputs.

Source files
------------

// File: rtl/fracclk_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package fracclk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Rounded phase increment for f_out from f_clk; meant for localparams in board tops.
  function automatic longint unsigned calc_inc(input longint unsigned f_out,
                                               input longint unsigned f_clk,
                                               input int              acc_w);
    return ((f_out << acc_w) + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/fracclk_acc.sv
// One tick channel: increment/enable registers, phase accumulator and tick flop.
// A config write realigns phase by clearing acc and tick on the write edge.
module fracclk_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             wr_en,
  output logic             tick
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic             en;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc  <= '0;
      en   <= 1'b0;
      acc  <= '0;
      tick <= 1'b0;
    end else if (wr) begin
      inc  <= wr_inc;
      en   <= wr_en;
      acc  <= '0;
      tick <= 1'b0;
    end else if (run && en) begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
    end else begin
      acc  <= '0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/fracclk_gen.sv
// Multi-channel fractional tick generator gated by a synchronised, filtered PLL lock.
// ready and rst_out_n are decoded straight from the state register.
module fracclk_gen
  import fracclk_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_FILTER = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pll_locked,
  input  logic                            cfg_we,
  input  logic [ch_width(CHANNELS)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]                cfg_inc,
  input  logic                            cfg_en,
  output logic [CHANNELS-1:0]             tick,
  output logic                            ready,
  output logic                            rst_out_n
);

  localparam int CH_W  = ch_width(CHANNELS);
  localparam int CNT_W = $clog2(LOCK_FILTER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

  logic             lock_meta;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Any lock drop while settling restarts the filter from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign run       = (state == RUN);
  assign ready     = run;
  assign rst_out_n = run;

  // Out-of-range cfg_ch matches no channel, so such writes fall away.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fracclk_acc #(.ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (run),
      .wr     (cfg_we && (cfg_ch == CH_W'(i))),
      .wr_inc (cfg_inc),
      .wr_en  (cfg_en),
      .tick   (tick[i])
    );
  end

endmodule
